// File: rtl/pll_power_sequencer.sv
// PLL power-up sequencer: power-on, reset hold, lock qualification, run.
// Drops to bypass on lock loss and parks in FAULT on lock timeout.
module pll_power_sequencer #(
    parameter int RST_CYCLES   = 100,
    parameter int LOCK_FILTER  = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       en,
    input  logic       req_enp,
    input  logic       req_enr,
    input  logic       clr_err,
    input  logic       pll_lock,
    output logic       pll_pwron,
    output logic       pll_rst,
    output logic       pll_bypass,
    output logic       pll_enp,
    output logic       pll_enr,
    output logic       ready,
    output logic [2:0] state,
    output logic       timeout_err,
    output logic       lock_lost
);

    localparam int MAX_AB = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_RST  = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_FLT  = 3'd4
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cyc_q, cyc_n;
    logic [CW-1:0] lck_q, lck_n;
    logic          to_set, ll_set;
    logic          pwron_n, rst_n_v, byp_n, enp_n, enr_n, rdy_n;

    // Saturating increment so counters never wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        lck_n   = lck_q;
        to_set  = 1'b0;
        ll_set  = 1'b0;
        if (!en) begin
            state_n = S_OFF;
            cyc_n   = '0;
            lck_n   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_n = S_RST;
                    cyc_n   = '0;
                    lck_n   = '0;
                end
                S_RST: begin
                    if (cyc_q == RST_LAST) begin
                        state_n = S_WAIT;
                        cyc_n   = '0;
                        lck_n   = '0;
                    end else begin
                        cyc_n = sat_inc(cyc_q);
                    end
                end
                S_WAIT: begin
                    cyc_n = sat_inc(cyc_q);
                    lck_n = pll_lock ? sat_inc(lck_q) : '0;
                    // Lock qualification beats a same-cycle timeout.
                    if (pll_lock && lck_q == LOCK_LAST) begin
                        state_n = S_RUN;
                        cyc_n   = '0;
                        lck_n   = '0;
                    end else if (cyc_q == TO_LAST) begin
                        state_n = S_FLT;
                        to_set  = 1'b1;
                        cyc_n   = '0;
                        lck_n   = '0;
                    end
                end
                S_RUN: begin
                    if (!pll_lock) begin
                        state_n = S_WAIT;
                        ll_set  = 1'b1;
                        cyc_n   = '0;
                        lck_n   = '0;
                    end
                end
                S_FLT: begin
                    state_n = S_FLT;
                end
                default: begin
                    state_n = S_OFF;
                    cyc_n   = '0;
                    lck_n   = '0;
                end
            endcase
        end

        pwron_n = 1'b0;
        rst_n_v = 1'b1;
        byp_n   = 1'b1;
        enp_n   = 1'b0;
        enr_n   = 1'b0;
        rdy_n   = 1'b0;
        case (state_n)
            S_RST: begin
                pwron_n = 1'b1;
            end
            S_WAIT: begin
                pwron_n = 1'b1;
                rst_n_v = 1'b0;
            end
            S_RUN: begin
                pwron_n = 1'b1;
                rst_n_v = 1'b0;
                byp_n   = 1'b0;
                enp_n   = req_enp;
                enr_n   = req_enr;
                rdy_n   = 1'b1;
            end
            default: begin
                pwron_n = 1'b0;
            end
        endcase
    end

    // State, counters and outputs all update on the same edge.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q    <= S_OFF;
            cyc_q      <= '0;
            lck_q      <= '0;
            pll_pwron  <= 1'b0;
            pll_rst    <= 1'b1;
            pll_bypass <= 1'b1;
            pll_enp    <= 1'b0;
            pll_enr    <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state_q    <= state_n;
            cyc_q      <= cyc_n;
            lck_q      <= lck_n;
            pll_pwron  <= pwron_n;
            pll_rst    <= rst_n_v;
            pll_bypass <= byp_n;
            pll_enp    <= enp_n;
            pll_enr    <= enr_n;
            ready      <= rdy_n;
        end
    end

    // Sticky error flags; a set event outranks a same-cycle clear.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            if (to_set)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
            if (ll_set)
                lock_lost <= 1'b1;
            else if (clr_err)
                lock_lost <= 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Directed bench for pll_power_sequencer with short timing parameters.
// Expected values are hand-derived from the sequencing rules.
module tb_pll_power_sequencer;

    logic       ref_clk = 1'b0;
    logic       reset, en, req_enp, req_enr, clr_err, pll_lock;
    logic       pll_pwron, pll_rst, pll_bypass, pll_enp, pll_enr;
    logic       ready, timeout_err, lock_lost;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    pll_power_sequencer #(
        .RST_CYCLES  (4),
        .LOCK_FILTER (3),
        .LOCK_TIMEOUT(20)
    ) dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .en         (en),
        .req_enp    (req_enp),
        .req_enr    (req_enr),
        .clr_err    (clr_err),
        .pll_lock   (pll_lock),
        .pll_pwron  (pll_pwron),
        .pll_rst    (pll_rst),
        .pll_bypass (pll_bypass),
        .pll_enp    (pll_enp),
        .pll_enr    (pll_enr),
        .ready      (ready),
        .state      (state),
        .timeout_err(timeout_err),
        .lock_lost  (lock_lost)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        req_enp  = 1'b0;
        req_enr  = 1'b0;
        clr_err  = 1'b0;
        pll_lock = 1'b0;
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_pllrst", pll_rst, 1);
        chk("rst_bypass", pll_bypass, 1);
        chk("rst_pwron", pll_pwron, 0);
        chk("rst_ready", ready, 0);
        chk("rst_flags", {timeout_err, lock_lost}, 0);
        reset = 1'b0;
        tick();
        chk("off_idle", state, 0);

        // Nominal bring-up
        en      = 1'b1;
        req_enp = 1'b1;
        tick();
        chk("nom_rst1", state, 1);
        chk("nom_rst1_pwron", pll_pwron, 1);
        chk("nom_rst1_rst", pll_rst, 1);
        tick(3);
        chk("nom_rst4", state, 1);
        tick();
        chk("nom_wait", state, 2);
        chk("nom_wait_rst", pll_rst, 0);
        chk("nom_wait_byp", pll_bypass, 1);
        pll_lock = 1'b1;
        tick(2);
        chk("nom_wait7", state, 2);
        tick();
        chk("nom_run", state, 3);
        chk("nom_ready", ready, 1);
        chk("nom_byp", pll_bypass, 0);
        chk("nom_enp", pll_enp, 1);
        chk("nom_enr", pll_enr, 0);
        req_enr = 1'b1;
        tick();
        chk("nom_enr_lat", pll_enr, 1);

        // Lock loss and relock
        pll_lock = 1'b0;
        tick();
        chk("ll_state", state, 2);
        chk("ll_enp", pll_enp, 0);
        chk("ll_byp", pll_bypass, 1);
        chk("ll_flag", lock_lost, 1);
        chk("ll_ready", ready, 0);
        pll_lock = 1'b1;
        tick(2);
        chk("ll_wait", state, 2);
        tick();
        chk("ll_relock", state, 3);
        chk("ll_sticky", lock_lost, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ll_clr", lock_lost, 0);

        // Reset during RUN, en ignored
        reset = 1'b1;
        tick();
        chk("rr_state", state, 0);
        chk("rr_enp", pll_enp, 0);
        chk("rr_pwron", pll_pwron, 0);
        chk("rr_flags", {timeout_err, lock_lost}, 0);
        reset = 1'b0;

        // Glitchy lock
        pll_lock = 1'b0;
        tick(5);
        chk("gl_wait", state, 2);
        pll_lock = 1'b1;
        tick(2);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick(2);
        chk("gl_not_yet", state, 2);
        tick();
        chk("gl_run", state, 3);

        // Abort during RST
        en = 1'b0;
        tick();
        chk("ab_off", state, 0);
        en = 1'b1;
        tick(2);
        chk("ab_rst2", state, 1);
        en = 1'b0;
        tick();
        chk("ab_state", state, 0);
        chk("ab_pwron", pll_pwron, 0);

        // Timeout
        en       = 1'b1;
        pll_lock = 1'b0;
        tick(5);
        chk("to_wait", state, 2);
        tick(19);
        chk("to_wait19", state, 2);
        chk("to_noerr", timeout_err, 0);
        tick();
        chk("to_fault", state, 4);
        chk("to_err", timeout_err, 1);
        chk("to_pwron", pll_pwron, 0);
        chk("to_rst", pll_rst, 1);
        tick(3);
        chk("to_held", state, 4);
        en = 1'b0;
        tick();
        chk("to_off", state, 0);
        chk("to_sticky", timeout_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clr", timeout_err, 0);

        // Lock on the timeout cycle wins
        en = 1'b1;
        tick(5);
        chk("sim_wait", state, 2);
        tick(17);
        pll_lock = 1'b1;
        tick(2);
        chk("sim_wait19", state, 2);
        tick();
        chk("sim_run", state, 3);
        chk("sim_noerr", timeout_err, 0);

        // Clear coinciding with lock loss
        pll_lock = 1'b0;
        clr_err  = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("sc_state", state, 2);
        chk("sc_flag", lock_lost, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
